// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM encodings, opcodes, instruction field positions
// and the branch-offset helper.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;

  // Fetch FSM state type and encodings
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE  = 2'd0;
  localparam fetch_state_t ST_FETCH = 2'd1;
  localparam fetch_state_t ST_HOLD  = 2'd2;
  localparam fetch_state_t ST_ERROR = 2'd3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam int unsigned OPCODE_MSB   = 31;
  localparam int unsigned OPCODE_LSB   = 26;
  localparam int unsigned FUNCT_MSB    = 5;
  localparam int unsigned FUNCT_LSB    = 0;
  localparam int unsigned IMM16_MSB    = 15;
  localparam int unsigned IMM16_LSB    = 0;
  localparam int unsigned TARGET26_MSB = 25;
  localparam int unsigned TARGET26_LSB = 0;

  // Sign-extended word offset of a branch immediate
  function automatic logic [INSTR_W-1:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/next_pc_logic.sv
// Combinational next-PC select: jump target, taken branch, or sequential pc_plus4.
// Jump takes priority over branch.
module next_pc_logic
  import mips_pkg::*;
(
  input  logic [INSTR_W-1:0] pc_plus4,
  input  logic [INSTR_W-1:0] instr,
  input  logic               branch,
  input  logic               zero,
  input  logic               jump,
  output logic [INSTR_W-1:0] next_pc
);

  // The opcode field does not steer the target; control decodes it into branch/jump.
  logic [5:0] w_unused_opcode;
  assign w_unused_opcode = instr[OPCODE_MSB:OPCODE_LSB];

  always_comb begin
    if (jump) begin
      next_pc = {pc_plus4[31:28], instr[TARGET26_MSB:TARGET26_LSB], 2'b00};
    end else if (branch && zero) begin
      next_pc = pc_plus4 + branch_offset(instr[IMM16_MSB:IMM16_LSB]);
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Sequential MIPS fetch stage: PC, instruction register and IDLE/FETCH/HOLD/ERROR FSM.
// Optional fetch-wait timeout is built only when FETCH_TIMEOUT_EN is defined.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        instr_ack,
  input  logic        branch,
  input  logic        zero,
  input  logic        jump,
  output logic        fetch_err
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_next_pc;
  logic         w_fetch_done;
  logic         w_timeout;

  assign w_fetch_done = (r_state == ST_FETCH) && imem_ready;
  assign w_pc_plus4   = r_pc + 32'd4;

`ifdef FETCH_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_wait_cnt;
  logic        r_fetch_err;

  // A ready in the limit cycle wins, so the timeout requires !imem_ready
  assign w_timeout = (r_state == ST_FETCH) && !imem_ready &&
                     ((r_wait_cnt + 16'd1) == TIMEOUT_LIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_fetch_err <= 1'b0;
    end else begin
      if ((w_state_next == ST_FETCH) && (r_state != ST_FETCH)) begin
        r_wait_cnt <= '0;
      end else if ((r_state == ST_FETCH) && !imem_ready) begin
        r_wait_cnt <= r_wait_cnt + 16'd1;
      end
      if (w_timeout) begin
        r_fetch_err <= 1'b1;
      end
    end
  end

  assign fetch_err = r_fetch_err;
`else
  logic [15:0] w_unused_timeout;
  assign w_unused_timeout = 16'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
  assign fetch_err        = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  w_state_next = ST_FETCH;
      ST_FETCH: begin
        if (imem_ready) begin
          w_state_next = ST_HOLD;
        end else if (w_timeout) begin
          w_state_next = ST_ERROR;
        end
      end
      ST_HOLD: begin
        if (instr_ack) begin
          w_state_next = ST_FETCH;
        end
      end
      ST_ERROR: w_state_next = ST_ERROR;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  next_pc_logic u_next_pc_logic (
    .pc_plus4 (w_pc_plus4),
    .instr    (r_instr),
    .branch   (branch),
    .zero     (zero),
    .jump     (jump),
    .next_pc  (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_fetch_done) begin
        r_instr <= imem_rdata;
      end
      if ((r_state == ST_HOLD) && instr_ack) begin
        r_pc <= w_next_pc;
      end
    end
  end

  assign imem_req    = (r_state == ST_FETCH);
  assign instr_valid = (r_state == ST_HOLD);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign instr       = r_instr;
  assign opcode      = r_instr[OPCODE_MSB:OPCODE_LSB];
  assign funct       = r_instr[FUNCT_MSB:FUNCT_LSB];

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Sequential fetch stage sitting directly upstream of the MIPS control unit and datapath. Holds the program counter and issues word fetches to instruction memory over a ready-based handshake. Presents the fetched instruction with its decoded `opcode`/`funct` fields to the control unit. On downstream acknowledge it advances the PC using the branch/jump outcome fed back from control and ALU.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `TIMEOUT_CYCLES`, 255, fetch-wait limit; used only with `FETCH_TIMEOUT_EN`; legal range 1..65535

Ports:
- `clk` in 1: single clock, all state updates on rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `imem_req` out 1: fetch request; high only in FETCH
- `imem_addr` out 32: equals `pc`; stable while `imem_req` is high
- `imem_ready` in 1: memory returns data this cycle; ignored outside FETCH
- `imem_rdata` in 32: instruction word; sampled only when `imem_req && imem_ready`
- `instr` out 32: latched instruction
- `instr_valid` out 1: `instr` valid for downstream
- `opcode` out 6: `instr[31:26]`
- `funct` out 6: `instr[5:0]`
- `pc` out 32: address of the current instruction
- `pc_plus4` out 32: `pc + 4`
- `instr_ack` in 1: downstream has executed `instr`; PC advances
- `branch` in 1: branch instruction, from control unit
- `zero` in 1: ALU zero flag
- `jump` in 1: jump instruction, from control unit
- `fetch_err` out 1: sticky fetch timeout

## Operation
- States: IDLE, FETCH, HOLD, ERROR.
  - ERROR is reachable only with `FETCH_TIMEOUT_EN`.
- IDLE → FETCH unconditionally on the next edge.
- FETCH:
  - `imem_req` = 1.
  - On `imem_ready`: latch `imem_rdata` into `instr` and go to HOLD.
  - Otherwise remain in FETCH.
- HOLD:
  - `instr_valid` = 1.
  - On `instr_ack`: load next PC and go to FETCH.
  - Otherwise hold `instr` and `pc` unchanged.
- Next PC, evaluated only in a HOLD cycle with `instr_ack`:
  - `jump`: `{pc_plus4[31:28], instr[25:0], 2'b00}`.
  - Else `branch && zero`: `pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
  - Else: `pc_plus4`.
  - Jump takes priority over branch.
- Arithmetic: all additions are 32-bit modulo 2^32. `pc` = 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
- `instr_ack` outside HOLD: ignored. `branch`, `zero`, `jump` outside the ack cycle: ignored.
- `imem_ready` high outside FETCH: ignored, no state change.

## Timing
- Reset values:
  - State IDLE; `pc` = `RESET_PC`; `instr` = 0; `instr_valid` = 0; `imem_req` = 0; `fetch_err` = 0.
  - Derived outputs follow from these: `opcode` = 0, `funct` = 0, `pc_plus4` = `RESET_PC` + 4.
- First `imem_req` is high in the second cycle after `rst_n` is sampled high (one IDLE cycle).
- `imem_req`, `imem_addr`, and `instr_valid` are decoded from registered state only; no input-to-output combinational path.
- Fetch latency: `instr_valid` rises the cycle after the edge at which `imem_ready` is sampled high.
- Minimum throughput: 2 cycles per instruction (FETCH with immediate ready, then HOLD with immediate ack).
- New `imem_addr` is presented the cycle after `instr_ack`.
- Reset mid-operation, in any state: the edge at which `rst_n` is sampled low forces reset values. A pending fetch is abandoned and a late `imem_ready` is ignored.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to FETCH and increments each FETCH cycle without `imem_ready`.
  - When the count reaches `TIMEOUT_CYCLES` without ready: set `fetch_err` and enter ERROR.
  - In ERROR: `imem_req` = 0 and `instr_valid` = 0; state is left only via reset.
  - `imem_ready` arriving in the same cycle the limit is reached wins: the fetch completes normally.
- Not defined:
  - FETCH waits indefinitely.
  - No counter is built.
  - `fetch_err` is tied to 0.

## Structure
- Shared package `mips_pkg`:
  - fetch state enum;
  - opcode constants;
  - `INSTR_W` = 32;
  - field-slice constants for opcode, funct, imm16, target26.
- One combinational sub-module, `next_pc_logic`: inputs `pc_plus4`, `instr`, `branch`, `zero`, `jump`; output next PC.
- FSM, PC, instruction register, and the optional timeout counter live in `instr_fetch_unit`.

## Test plan
- Reset release, `RESET_PC` = 0, `imem_ready` tied high, `instr_ack` tied high → `imem_addr` sequence 0, 4, 8, 12, one new address every 2 cycles.
- Fetch 32'h1000_0003 at PC 0x40, `branch` = 1, `zero` = 1, ack → next `imem_addr` = 0x50. Same with `zero` = 0 → 0x44.
- Fetch 32'h0800_0100 at 0x0000_1000, `jump` = 1 and `branch` = 1 simultaneously → next `imem_addr` = 0x0000_0400 (jump wins).
- `imem_ready` held low for 5 cycles; `instr_ack` pulsed during FETCH → `imem_addr` held, ack ignored, `instr_valid` rises 1 cycle after ready.
- `rst_n` low while in HOLD with `instr_valid` = 1 → next cycle `instr_valid` = 0, `pc` = `RESET_PC`; a `imem_ready` pulse during reset is ignored.
- With `FETCH_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 4, ready never asserted → `fetch_err` = 1 and `imem_req` = 0 after 4 FETCH cycles, held until reset. Without the macro, `fetch_err` stays 0.
